axi_lite_reg_arbiter: RTL

Shares the single S00_AXI AXI4-Lite register port of rd_interface between two on-chip requesters, for example the trigger sequencer and the PS-side config mailbox. Each requester issues single-word read or write commands on a simple valid/ack interface. The block arbitrates round-robin, runs one complete AXI4-Lite transaction at a time as master, and returns read data and response to the granted requester.

---
 rtl/axi_lite_reg_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_reg_arbiter.sv
// Two-requester round-robin front end that runs one AXI4-Lite transaction at a time
// as master and returns the response/read data to whichever requester was granted.
//
// state  | meaning
// IDLE   | wait for a request, pick a grant, latch its command
// WR     | AWVALID/WVALID up, each drops after its own handshake
// WRESP  | BREADY up, waiting for BVALID
// RADDR  | ARVALID up, waiting for ARREADY
// RDATA  | RREADY up, waiting for RVALID
// DONE   | req_ack pulse to the granted requester
module axi_lite_reg_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ack,
  output logic [DATA_W-1:0]     req_rdata,
  output logic [1:0]            req_resp,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WRESP, S_RADDR, S_RDATA, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [1:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic                g;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    // Pointer only matters on a tie; a lone requester always wins.
    g         = (&req_valid) ? ptr_q : req_valid[1];

    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          gnt_d  = g;
          ptr_d  = ~g;
          addr_d = g ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          if (req_we[g]) begin
            wdata_d   = g ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end
        end
      end
      S_WR: begin
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI_WREADY;
        // A channel whose valid is already low has completed its handshake.
        if ((~awvalid_q | M_AXI_AWREADY) & (~wvalid_q | M_AXI_WREADY)) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          resp_d   = M_AXI_BRESP;
          bready_d = 1'b0;
          ack_d    = gnt_q ? 2'b10 : 2'b01;
          state_d  = S_DONE;
        end
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          rdata_d  = M_AXI_RDATA;
          resp_d   = M_AXI_RRESP;
          rready_d = 1'b0;
          ack_d    = gnt_q ? 2'b10 : 2'b01;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ack       = ack_q;
  assign req_rdata     = rdata_q;
  assign req_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
